// File: rtl/grid_line_clear_pkg.sv
// rtl/grid_line_clear_pkg.sv - shared grid geometry, pass state encoding and address helper
// Purpose: constants shared by the grid writer (line clear) and the grid video reader.
// Contents: COLS/ROWS/ADDR_W/DATA_W/EMPTY, derived widths, state_t, cell_addr().
package grid_line_clear_pkg;

  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] EMPTY = '0;

  // Row pointers carry one extra bit so stepping below row 0 sets the MSB.
  localparam int PTR_W = $clog2(ROWS) + 1;
  // Column index must reach COLS (the final capture cycle of a row read).
  localparam int IDX_W = $clog2(COLS + 1);
  localparam int CNT_W = 5;

  localparam logic [PTR_W-1:0] ROW_BOTTOM = PTR_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_COL   = IDX_W'(COLS - 1);
  localparam logic [IDX_W-1:0] COL_END    = IDX_W'(COLS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    FILL  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Only called with a non-negative row; ROWS*COLS-1 fits ADDR_W, so no truncation.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [PTR_W-1:0] row,
                                                  input logic [IDX_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/grid_line_clear_row_buffer.sv
// rtl/grid_line_clear_row_buffer.sv - one-row capture buffer with running full flag
// Purpose: holds the row just read from grid memory and tracks whether every cell is occupied.
// Ports: clk, reset (sync, active-high); clear re-arms the full flag; capture writes
//        cap_data into slot cap_idx; rd_idx/rd_data read a slot; full is the running AND.
module grid_line_clear_row_buffer
  import grid_line_clear_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              capture,
  input  logic [IDX_W-1:0]  cap_idx,
  input  logic [DATA_W-1:0] cap_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              full
);

  logic [DATA_W-1:0] cells [COLS];
  logic              full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b1;
      for (int i = 0; i < COLS; i++) cells[i] <= EMPTY;
    end else if (clear) begin
      full_q <= 1'b1;
    end else if (capture) begin
      cells[cap_idx] <= cap_data;
      full_q         <= full_q & (cap_data != EMPTY);
    end
  end

  assign rd_data = cells[rd_idx];
  assign full    = full_q;

endmodule

// File: rtl/grid_line_clear.sv
// rtl/grid_line_clear.sv - removes full rows from the grid memory, compacting downward
// Purpose: on start, scans rows bottom-to-top; full rows are dropped, surviving rows are
//          rewritten lower, vacated top rows are zero-filled.
// Ports: clk, reset (sync, active-high), start; busy, done, lines_cleared status;
//        grid_addr/grid_wdata/grid_we drive the spare memory port; grid_rdata is the
//        registered read data (valid one cycle after grid_addr).
module grid_line_clear
  import grid_line_clear_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  lines_cleared,
  output logic [ADDR_W-1:0] grid_addr,
  output logic [DATA_W-1:0] grid_wdata,
  output logic              grid_we,
  input  logic [DATA_W-1:0] grid_rdata
);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  src_q, src_d, dst_q, dst_d;
  logic [IDX_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  count_q, count_d, lines_q, lines_d;

  logic              row_done;
  logic              buf_clear, buf_capture, buf_full;
  logic [IDX_W-1:0]  buf_cap_idx;
  logic [DATA_W-1:0] buf_rd_data;

  grid_line_clear_row_buffer u_row_buffer (
    .clk      (clk),
    .reset    (reset),
    .clear    (buf_clear),
    .capture  (buf_capture),
    .cap_idx  (buf_cap_idx),
    .cap_data (grid_rdata),
    .rd_idx   (col_q),
    .rd_data  (buf_rd_data),
    .full     (buf_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      col_q   <= '0;
      count_q <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      col_q   <= col_d;
      count_q <= count_d;
      lines_q <= lines_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    col_d       = col_q;
    count_d     = count_q;
    lines_d     = lines_q;
    row_done    = 1'b0;
    buf_clear   = 1'b0;
    buf_capture = 1'b0;
    buf_cap_idx = col_q - IDX_W'(1);
    grid_addr   = '0;
    grid_wdata  = EMPTY;
    grid_we     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = ROW_BOTTOM;
          dst_d   = ROW_BOTTOM;
          col_d   = '0;
          count_d = '0;
          state_d = READ;
        end
      end

      // Address for column k goes out on cycle k; its data lands on cycle k+1,
      // so the capture index trails col_q by one and the row takes COLS+1 cycles.
      READ: begin
        busy        = 1'b1;
        buf_clear   = (col_q == '0);
        buf_capture = (col_q != '0);
        if (col_q == COL_END) begin
          col_d   = '0;
          state_d = CHECK;
        end else begin
          grid_addr = cell_addr(src_q, col_q);
          col_d     = col_q + IDX_W'(1);
        end
      end

      CHECK: begin
        busy = 1'b1;
        if (buf_full) begin
          count_d  = count_q + CNT_W'(1);
          src_d    = src_q - PTR_W'(1);
          row_done = 1'b1;
        end else if (src_q == dst_q) begin
          // Nothing cleared below yet: the row is already in place.
          src_d    = src_q - PTR_W'(1);
          dst_d    = dst_q - PTR_W'(1);
          row_done = 1'b1;
        end else begin
          col_d   = '0;
          state_d = WRITE;
        end
      end

      WRITE: begin
        busy       = 1'b1;
        grid_we    = 1'b1;
        grid_addr  = cell_addr(dst_q, col_q);
        grid_wdata = buf_rd_data;
        if (col_q == LAST_COL) begin
          src_d    = src_q - PTR_W'(1);
          dst_d    = dst_q - PTR_W'(1);
          row_done = 1'b1;
        end else begin
          col_d = col_q + IDX_W'(1);
        end
      end

      FILL: begin
        busy       = 1'b1;
        grid_we    = 1'b1;
        grid_addr  = cell_addr(dst_q, col_q);
        grid_wdata = EMPTY;
        if (col_q == LAST_COL) begin
          col_d = '0;
          dst_d = dst_q - PTR_W'(1);
          if (dst_q == '0) state_d = DONE;
        end else begin
          col_d = col_q + IDX_W'(1);
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Pointer MSB set means the pointer stepped past row 0.
    if (row_done) begin
      col_d = '0;
      if (!src_d[PTR_W-1])      state_d = READ;
      else if (!dst_d[PTR_W-1]) state_d = FILL;
      else                      state_d = DONE;
    end

    // Publish the count as the pass enters DONE so it is valid alongside the done pulse.
    if (state_d == DONE && state_q != DONE) lines_d = count_d;
  end

  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_grid_line_clear.sv
// tb/tb_grid_line_clear.sv - randomized and directed self-checking bench for grid_line_clear
module tb_grid_line_clear;
  import grid_line_clear_pkg::*;

  localparam int CELLS = ROWS * COLS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, grid_we;
  logic [CNT_W-1:0]  lines_cleared;
  logic [ADDR_W-1:0] grid_addr;
  logic [DATA_W-1:0] grid_wdata;
  logic [DATA_W-1:0] grid_rdata;

  logic [DATA_W-1:0] mem      [CELLS];
  logic [DATA_W-1:0] init_mem [CELLS];
  logic [DATA_W-1:0] exp_mem  [CELLS];
  logic              load = 1'b0;
  int                exp_cleared, exp_moved;
  int                total = 0, bad = 0;

  grid_line_clear dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .grid_addr     (grid_addr),
    .grid_wdata    (grid_wdata),
    .grid_we       (grid_we),
    .grid_rdata    (grid_rdata)
  );

  always #5 clk = ~clk;

  // Dual-port grid memory, spare port only: registered read, write on grid_we.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= init_mem[i];
    end else begin
      if (int'(grid_addr) < CELLS) grid_rdata <= mem[grid_addr];
      else grid_rdata <= '0;
      if (grid_we && int'(grid_addr) < CELLS) mem[grid_addr] <= grid_wdata;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load_grid();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic clear_init();
    for (int i = 0; i < CELLS; i++) init_mem[i] = EMPTY;
  endtask

  // Reference: keep non-full rows in bottom-up order, stack them at the bottom,
  // everything above is empty. A kept row is "moved" if any full row lay below it.
  task automatic compute_model();
    int d;
    bit full;
    d = ROWS - 1;
    exp_cleared = 0;
    exp_moved = 0;
    for (int i = 0; i < CELLS; i++) exp_mem[i] = EMPTY;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (mem[r*COLS+c] == EMPTY) full = 1'b0;
      if (full) exp_cleared++;
      else begin
        if (r != d) exp_moved++;
        for (int c = 0; c < COLS; c++) exp_mem[d*COLS+c] = mem[r*COLS+c];
        d--;
      end
    end
  endtask

  task automatic run_pass(input string tag, input int hold, input int repulse);
    int cyc, dones, wes, stray, lat, exp_lat;
    bit seen;
    compute_model();
    exp_lat = ROWS*(COLS+2) + COLS*(exp_moved + exp_cleared) + 1;
    cyc = 0; dones = 0; wes = 0; stray = 0; lat = 0; seen = 1'b0;
    @(negedge clk) start = 1'b1;
    while (!seen && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc < hold) || (cyc == repulse);
      if (grid_we) begin
        wes++;
        if (!busy || int'(grid_addr) >= CELLS) stray++;
      end
      if (done) begin
        seen = 1'b1;
        lat = cyc;
        dones++;
        check({tag, " lines_cleared"}, int'(lines_cleared), exp_cleared);
        check({tag, " busy_at_done"}, int'(busy), 0);
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, int'(seen), 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " write_cycles"}, wes, COLS*(exp_moved + exp_cleared));
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (grid_we) stray++;
    end
    check({tag, " done_pulses"}, dones, 1);
    check({tag, " stray_writes"}, stray, 0);
    check({tag, " lines_held"}, int'(lines_cleared), exp_cleared);
    for (int i = 0; i < CELLS; i++)
      check($sformatf("%s cell%0d", tag, i), int'(mem[i]), int'(exp_mem[i]));
  endtask

  task automatic build_scenario2();
    clear_init();
    for (int c = 0; c < COLS; c++) init_mem[19*COLS+c] = 8'h03;
    init_mem[18*COLS+4] = 8'h05;
  endtask

  initial begin
    int wes, cyc;
    clear_init();
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset we", int'(grid_we), 0);
    check("reset addr", int'(grid_addr), 0);
    check("reset wdata", int'(grid_wdata), 0);
    check("reset lines", int'(lines_cleared), 0);
    reset = 1'b0;

    // 1: empty grid
    clear_init();
    load_grid();
    run_pass("empty", 1, 0);

    // 2: one full row with a sparse row above
    build_scenario2();
    load_grid();
    run_pass("scen2", 1, 0);

    // 3: two full rows interleaved with partial rows
    clear_init();
    for (int c = 0; c < COLS; c++) begin
      init_mem[19*COLS+c] = 8'h02;
      init_mem[17*COLS+c] = 8'h02;
    end
    for (int c = 0; c < COLS-1; c++) init_mem[18*COLS+c] = 8'h04;
    init_mem[16*COLS] = 8'h07;
    load_grid();
    run_pass("scen3", 1, 0);

    // 4: whole grid full
    for (int i = 0; i < CELLS; i++) init_mem[i] = 8'h01;
    load_grid();
    run_pass("allfull", 1, 0);

    // 5: reset during the 3rd write cycle of scenario 2, then a clean pass
    build_scenario2();
    load_grid();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wes = 0; cyc = 0;
    while (wes < 3 && cyc < 2000) begin
      if (grid_we) wes++;
      if (wes < 3) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("rst3 reached_write", wes, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst3 busy", int'(busy), 0);
    check("rst3 we", int'(grid_we), 0);
    check("rst3 done", int'(done), 0);
    check("rst3 lines", int'(lines_cleared), 0);
    check("rst3 addr", int'(grid_addr), 0);
    @(negedge clk) reset = 1'b0;
    run_pass("after_rst", 1, 0);

    // 6: start held 3 cycles and re-pulsed mid-pass
    build_scenario2();
    load_grid();
    run_pass("restart", 3, 60);

    // random grids, random start hold / re-pulse
    for (int p = 0; p < 8; p++) begin
      for (int r = 0; r < ROWS; r++) begin
        int mode;
        mode = $urandom_range(0, 3);
        for (int c = 0; c < COLS; c++) begin
          if (mode == 0) init_mem[r*COLS+c] = DATA_W'($urandom_range(1, 255));
          else if (mode == 1) init_mem[r*COLS+c] = EMPTY;
          else init_mem[r*COLS+c] = ($urandom_range(0, 4) == 0) ? EMPTY
                                    : DATA_W'($urandom_range(1, 255));
        end
      end
      load_grid();
      run_pass($sformatf("rand%0d", p), $urandom_range(1, 3), $urandom_range(5, 200));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
